// File: rtl/scan_gold_chain.sv
`default_nettype none
// ============================================================================
// Module  : scan_gold_chain
// Brief   : Multi-chain scan frame checker; shifts captured words out MSB-first
//           and counts cycles where any chain differs from a golden register.
//           Optional macro SCAN_GOLD_LOOP_EN recirculates each chain's MSB.
// Revision: 1.0
// ============================================================================
module scan_gold_chain #(
    parameter int WIDTH  = 8,
    parameter int CHAINS = 1,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      load_gold_n,
    input  logic                      capture,
    input  logic                      scan_en,
    input  logic [WIDTH*CHAINS-1:0]   din,
    input  logic [CHAINS-1:0]         scan_in,
    output logic [CHAINS-1:0]         scan_out,
    output logic                      busy,
    output logic                      done,
    output logic                      mismatch,
    output logic [CNT_W-1:0]          err_count
);

    localparam int            DW       = WIDTH * CHAINS;
    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [DW-1:0]      r_s;
    logic [DW-1:0]      r_gold;
    logic [BW-1:0]      r_bitcnt;
    logic [CNT_W-1:0]   r_err;
    logic               r_mismatch;

    logic [CHAINS-1:0]  w_msb;
    logic [CHAINS-1:0]  w_lsb_in;
    logic [CHAINS-1:0]  w_bit_mm;
    logic [DW-1:0]      w_s_next;
    logic               w_any_mm;

    genvar c;
    generate
        for (c = 0; c < CHAINS; c++) begin : g_chain
            logic [WIDTH-1:0] w_gold_c;
            assign w_gold_c    = r_gold[c*WIDTH +: WIDTH];
            assign w_msb[c]    = r_s[c*WIDTH + WIDTH - 1];
`ifdef SCAN_GOLD_LOOP_EN
            assign w_lsb_in[c] = w_msb[c];
`else
            assign w_lsb_in[c] = scan_in[c];
`endif
            // bit leaving the chain this cycle is golden bit WIDTH-1-bitcnt
            assign w_bit_mm[c] = w_msb[c] ^ w_gold_c[LAST_BIT - r_bitcnt];
            assign w_s_next[c*WIDTH +: WIDTH] = {r_s[c*WIDTH +: WIDTH-1], w_lsb_in[c]};
        end
    endgenerate

`ifdef SCAN_GOLD_LOOP_EN
    logic w_unused;
    assign w_unused = ^scan_in;
`endif

    assign w_any_mm  = |w_bit_mm;
    assign scan_out  = w_msb;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign mismatch  = r_mismatch;
    assign err_count = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_gold     <= '0;
            r_bitcnt   <= '0;
            r_err      <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if (!load_gold_n) begin
                r_gold <= din;
            end
            case (r_state)
                IDLE: begin
                    if (capture) begin
                        r_s        <= din;
                        r_bitcnt   <= '0;
                        r_err      <= '0;
                        r_mismatch <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (scan_en) begin
                        r_s <= w_s_next;
                        if (w_any_mm) begin
                            r_mismatch <= 1'b1;
                            if (r_err != {CNT_W{1'b1}}) begin
                                r_err <= r_err + 1'b1;
                            end
                        end
                        if (r_bitcnt == LAST_BIT) begin
                            r_state <= DONE;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_gold_chain.sv
`default_nettype none
// ============================================================================
// Module  : tb_scan_gold_chain
// Brief   : Randomised scoreboard bench for scan_gold_chain (two 8-bit chains,
//           3-bit error counter) with a FIFO-per-chain reference model.
// Revision: 1.0
// ============================================================================
module tb_scan_gold_chain;

    localparam int W    = 8;
    localparam int C    = 2;
    localparam int CW   = 3;
    localparam int DW   = W * C;
    localparam int MAXE = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          load_gold_n = 1'b1;
    logic          capture = 1'b0;
    logic          scan_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [C-1:0]  scan_in = '0;
    logic [C-1:0]  scan_out;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [CW-1:0] err_count;

    scan_gold_chain #(.WIDTH(W), .CHAINS(C), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .load_gold_n(load_gold_n), .capture(capture),
        .scan_en(scan_en), .din(din), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           err;
        bit           mm;
        logic [C-1:0] last_msb;
    } frame_t;

    logic [C-1:0]  exp_bits[$];
    frame_t        exp_frames[$];
    logic [DW-1:0] gold_m = '0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            n_shift = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the golden model follows the load strobe the DUT saw.
    task automatic cycle_edge();
        @(posedge clk);
        if (!load_gold_n) gold_m = din;
        #1;
    endtask

    task automatic load_gold(input logic [DW-1:0] v);
        load_gold_n = 1'b0;
        din = v;
        cycle_edge();
        load_gold_n = 1'b1;
    endtask

    task automatic run_frame(input logic [DW-1:0] cap, input bit gold_at_cap,
                             input int stall_pct, input int gold_pct,
                             input bit si_ones, input int abort_at);
        logic [C-1:0] fifo[$];
        logic [C-1:0] v;
        logic [C-1:0] outb;
        int  shifts;
        int  err;
        bit  mm;
        bit  any;
        shifts = 0;
        err = 0;
        mm = 1'b0;
        fifo = {};
        for (int k = 0; k < W; k++) begin
            for (int ch = 0; ch < C; ch++) v[ch] = cap[ch*W + W-1-k];
            fifo.push_back(v);
        end
        capture = 1'b1;
        din = cap;
        load_gold_n = !gold_at_cap;
        scan_en = 1'($urandom_range(0, 1));
        scan_in = C'($urandom);
        cycle_edge();
        capture = 1'b0;
        load_gold_n = 1'b1;
        while (shifts < W) begin
            if (shifts == abort_at) begin
                rstn = 1'b0;
                scan_en = 1'b0;
                load_gold_n = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err_count, 0);
                chk("rst_mismatch", mismatch, 0);
                chk("rst_scan_out", scan_out, 0);
                exp_bits.delete();
                exp_frames.delete();
                gold_m = '0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
                return;
            end
            scan_en = ($urandom_range(0, 99) >= stall_pct);
            scan_in = si_ones ? {C{1'b1}} : C'($urandom);
            load_gold_n = !($urandom_range(0, 99) < gold_pct);
            din = DW'($urandom);
            capture = ($urandom_range(0, 3) == 0);
            if (scan_en) begin
                outb = fifo.pop_front();
`ifdef SCAN_GOLD_LOOP_EN
                fifo.push_back(outb);
`else
                fifo.push_back(scan_in);
`endif
                any = 1'b0;
                for (int ch = 0; ch < C; ch++)
                    if (outb[ch] != gold_m[ch*W + W-1-shifts]) any = 1'b1;
                if (any) begin
                    mm = 1'b1;
                    if (err < MAXE) err++;
                end
                exp_bits.push_back(outb);
                shifts++;
                if (shifts == W) exp_frames.push_back('{err, mm, fifo[0]});
            end
            cycle_edge();
        end
        scan_en = 1'($urandom_range(0, 1));
        capture = 1'($urandom_range(0, 1));
        load_gold_n = 1'b1;
        cycle_edge();
        capture = 1'b0;
        scan_en = 1'b0;
    endtask

    // Monitor: consumes expected shift bits and frame results as the DUT shows them.
    always @(negedge clk) begin
        logic [C-1:0] e;
        frame_t       f;
        if (!rstn) begin
            n_shift = 0;
        end else begin
            if (busy && !done && scan_en) begin
                chk("shift_expected", 32'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) begin
                    e = exp_bits.pop_front();
                    chk("scan_out", scan_out, e);
                end
                n_shift++;
            end
            if (done) begin
                chk("done_shifts", n_shift, W);
                chk("done_busy", busy, 1);
                n_shift = 0;
                chk("done_expected", 32'(exp_frames.size() > 0), 1);
                if (exp_frames.size() > 0) begin
                    f = exp_frames.pop_front();
                    chk("frame_err", err_count, f.err);
                    chk("frame_mismatch", mismatch, f.mm);
                    chk("frame_last_msb", scan_out, f.last_msb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err_count, 0);
        chk("reset_mismatch", mismatch, 0);
        chk("reset_scan_out", scan_out, 0);
        rstn = 1'b1;
        cycle_edge();

        // Gold and capture in the same cycle: clean frame.
        run_frame(16'hA5A5, 1'b1, 0, 0, 1'b0, -1);
        chk("clean_err", err_count, 0);
        chk("clean_mismatch", mismatch, 0);

        // Single-bit difference on the last shift of chain 0.
        run_frame(16'hA5A4, 1'b0, 0, 0, 1'b0, -1);
        chk("lastbit_err", err_count, 1);
        chk("lastbit_mismatch", mismatch, 1);
        load_gold(DW'($urandom));
        cycle_edge();
        chk("hold_err", err_count, 1);
        chk("hold_mismatch", mismatch, 1);

        // Stalls with all-ones serial input.
        load_gold(16'hFFFF);
        run_frame(16'hFFFF, 1'b0, 50, 0, 1'b1, -1);
        chk("stall_err", err_count, 0);
        chk("stall_scan_out", scan_out, 2'b11);

        // Both chains differ on the same four cycles: counts cycles, not bits.
        load_gold(16'h0F0F);
        run_frame(16'h0000, 1'b0, 20, 0, 1'b0, -1);
        chk("cycles_err", err_count, 4);

        // Saturation.
        load_gold(16'h0000);
        run_frame(16'hFFFF, 1'b0, 0, 0, 1'b0, -1);
        chk("sat_err", err_count, MAXE);
        chk("sat_mismatch", mismatch, 1);

        // Reset after three shifts, then a frame against the cleared gold.
        load_gold(16'hFFFF);
        run_frame(DW'($urandom), 1'b0, 0, 0, 1'b0, 3);
        run_frame(16'h0003, 1'b0, 0, 0, 1'b0, -1);
        chk("post_reset_err", err_count, 2);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) load_gold(DW'($urandom));
            run_frame(DW'($urandom), 1'($urandom_range(0, 1)), 30, 15, 1'b0, -1);
            repeat ($urandom_range(0, 2)) cycle_edge();
        end

        repeat (5) cycle_edge();
        chk("leftover_bits", exp_bits.size(), 0);
        chk("leftover_frames", exp_frames.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
